// File: rtl/i2c_pkg.sv
// ============================================================================
// Module   : i2c_pkg
// Brief    : Shared types and constants for the I2C target register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

    localparam int unsigned BITCNT_W = 3;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } i2c_state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_line_filter.sv
// ============================================================================
// Module   : i2c_line_filter
// Brief    : 2-flop synchroniser, FILTER_LEN-sample glitch filter, edge pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_line_filter #(
    parameter int FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       sync_q;
    logic             filt_q;
    logic             filt_d;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            filt_q <= 1'b1;
            prev_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            filt_q <= filt_d;
            prev_q <= filt_q;
            cnt_q  <= cnt_d;
        end
    end

    // The level flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o = filt_q;
    assign rise_o  = filt_q & ~prev_q;
    assign fall_o  = ~filt_q & prev_q;

endmodule

`default_nettype wire

// File: rtl/i2c_target_regfile.sv
// ============================================================================
// Module   : i2c_target_regfile
// Brief    : I2C target serving a byte register file with pointer auto-increment.
//            General-call support is enabled by defining I2C_TARGET_GENCALL_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_target_regfile #(
    parameter logic [6:0] DEV_ADDR   = 7'h39,
    parameter int         REG_AW     = 4,
    parameter int         FILTER_LEN = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              SCL_In,
    input  logic              SDA_In,
    output logic              SDA_Oe,
    output logic              Wr_Strobe,
    output logic [REG_AW-1:0] Wr_Addr,
    output logic [7:0]        Wr_Data,
`ifdef I2C_TARGET_GENCALL_EN
    output logic              Gencall_Strobe,
`endif
    output logic              Busy
);

    import i2c_pkg::*;

    localparam int NREG = 2 ** REG_AW;
`ifdef I2C_TARGET_GENCALL_EN
    localparam bit GENCALL_EN = 1'b1;
`else
    localparam bit GENCALL_EN = 1'b0;
`endif

    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_last, w_commit;
    logic [7:0] w_byte;

    i2c_state_e          state_q, state_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                rw_q, rw_d;
    logic                gc_q, gc_d;
    logic [REG_AW-1:0]   ptr_q, ptr_d;
    logic                sda_oe_q, sda_oe_d;
    logic                wr_pend_q, wr_pend_d;
    logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [7:0]          regs_q [NREG];

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .line_i  (SCL_In),
        .level_o (w_scl),
        .rise_o  (w_scl_rise),
        .fall_o  (w_scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .line_i  (SDA_In),
        .level_o (w_sda),
        .rise_o  (w_sda_rise),
        .fall_o  (w_sda_fall)
    );

    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;
    assign w_byte  = {shift_q[6:0], w_sda};
    assign w_last  = &bitcnt_q;
    // A received byte is committed one cycle later so a coincident STOP can veto it.
    assign w_commit = wr_pend_q & ~w_stop & ~Reset;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            bitcnt_q  <= '0;
            shift_q   <= '0;
            rw_q      <= 1'b0;
            gc_q      <= 1'b0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            rw_q      <= rw_d;
            gc_q      <= gc_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            if (w_commit) begin
                regs_q[wr_addr_q] <= wr_data_q;
            end
        end
    end

    // Bit counter is 3 bits wide, so the increment on the 8th rise wraps it to 0.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        rw_d      = rw_q;
        gc_d      = gc_q;
        ptr_d     = ptr_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (w_commit) begin
            ptr_d = wr_addr_q + 1'b1;
        end
        if (w_stop) begin
            state_d = ST_IDLE;
        end else if (w_start) begin
            state_d  = ST_ADDR;
            bitcnt_d = '0;
            gc_d     = 1'b0;
        end else if (w_scl_rise) begin
            case (state_q)
                ST_ADDR: begin
                    shift_d  = w_byte;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (w_last) begin
                        if (w_byte[7:1] == DEV_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = w_byte[0];
                        end else if (GENCALL_EN && (w_byte == 8'h00)) begin
                            state_d = ST_ADDR_ACK;
                            rw_d    = 1'b0;
                            gc_d    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (rw_q) begin
                        state_d = ST_RDATA;
                        shift_d = regs_q[ptr_q];
                    end else begin
                        state_d = ST_PTR;
                    end
                end
                ST_PTR: begin
                    shift_d  = w_byte;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (w_last) begin
                        state_d = ST_PTR_ACK;
                        if (!gc_q) begin
                            ptr_d = w_byte[REG_AW-1:0];
                        end
                    end
                end
                ST_PTR_ACK: begin
                    state_d = ST_WDATA;
                end
                ST_WDATA: begin
                    shift_d  = w_byte;
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (w_last) begin
                        if (gc_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d   = ST_WDATA_ACK;
                            wr_pend_d = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = w_byte;
                        end
                    end
                end
                ST_WDATA_ACK: begin
                    state_d = ST_WDATA;
                end
                ST_RDATA: begin
                    shift_d  = {shift_q[6:0], 1'b0};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (w_last) begin
                        state_d = ST_RDATA_ACK;
                        ptr_d   = ptr_q + 1'b1;
                    end
                end
                ST_RDATA_ACK: begin
                    if (w_sda == I2C_ACK) begin
                        state_d = ST_RDATA;
                        shift_d = regs_q[ptr_q];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // SDA changes only after SCL has fallen; ACK slots pull low, read bits drive the MSB.
    always_comb begin
        sda_oe_d = sda_oe_q;
        if (w_start || w_stop) begin
            sda_oe_d = 1'b0;
        end else if (w_scl_fall) begin
            case (state_q)
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: sda_oe_d = 1'b1;
                ST_RDATA:                              sda_oe_d = ~shift_q[7];
                default:                               sda_oe_d = 1'b0;
            endcase
        end
        Busy = (state_q != ST_IDLE) && (state_q != ST_ADDR);
    end

    assign SDA_Oe    = sda_oe_q;
    assign Wr_Strobe = w_commit;
    assign Wr_Addr   = wr_addr_q;
    assign Wr_Data   = wr_data_q;

`ifdef I2C_TARGET_GENCALL_EN
    logic gc_strobe_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            gc_strobe_q <= 1'b0;
        end else begin
            gc_strobe_q <= gc_q && (state_q == ST_PTR) && w_scl_rise && w_last
                           && !w_start && !w_stop;
        end
    end

    assign Gencall_Strobe = gc_strobe_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
// ============================================================================
// Module   : tb_i2c_target_regfile
// Brief    : Bus-level bench for i2c_target_regfile with write/read scoreboards.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_target_regfile;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_drv = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       wr_strobe;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
`ifdef I2C_TARGET_GENCALL_EN
    logic       gc_strobe;
    int         gc_cnt = 0;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    int          oe_cnt = 0;
    int          busy_cnt = 0;
    int          wr_unexp = 0;
    logic [11:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [11:0] wr_e;

    always #5 clk = ~clk;

    assign sda_line = sda_drv & ~sda_oe;

    i2c_target_regfile #(
        .DEV_ADDR   (7'h39),
        .REG_AW     (4),
        .FILTER_LEN (3)
    ) dut (
        .Clock          (clk),
        .Reset          (rst),
        .SCL_In         (scl_drv),
        .SDA_In         (sda_line),
        .SDA_Oe         (sda_oe),
        .Wr_Strobe      (wr_strobe),
        .Wr_Addr        (wr_addr),
        .Wr_Data        (wr_data),
`ifdef I2C_TARGET_GENCALL_EN
        .Gencall_Strobe (gc_strobe),
`endif
        .Busy           (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sda_oe) oe_cnt <= oe_cnt + 1;
            if (busy)   busy_cnt <= busy_cnt + 1;
`ifdef I2C_TARGET_GENCALL_EN
            if (gc_strobe) gc_cnt <= gc_cnt + 1;
`endif
            if (wr_strobe) begin
                if (exp_wr_q.size() == 0) begin
                    wr_unexp <= wr_unexp + 1;
                end else begin
                    wr_e = exp_wr_q.pop_front();
                    check_val("wr_event", 32'({wr_addr, wr_data}), 32'(wr_e));
                end
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
    endtask

    task automatic bus_recover();
        scl_drv = 1'b0; wait_q();
        bus_stop();
    endtask

    task automatic send_bit(input logic b, input bit glitch, output logic seen);
        sda_drv = b; wait_q();
        scl_drv = 1'b1; wait_q();
        if (glitch) begin
            sda_drv = ~b;
            @(negedge clk);
            sda_drv = b;
        end
        seen = sda_line;
        wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, input bit glitch_en, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i], glitch_en && (i >= 6), d);
        end
        send_bit(1'b1, 1'b0, ack);
    endtask

    task automatic wr_byte_chk(input logic [7:0] b, input logic exp_ack, input string tag);
        logic ack;
        write_byte(b, 1'b0, ack);
        check_val(tag, 32'(ack), 32'(exp_ack));
    endtask

    task automatic wr_data_exp(input logic [3:0] a, input logic [7:0] d, input string tag);
        exp_wr_q.push_back({a, d});
        wr_byte_chk(d, 1'b0, tag);
    endtask

    task automatic read_byte(input logic ack_out, input string tag);
        logic [7:0] b;
        logic       v;
        logic       e;
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b1, 1'b0, v);
            b[i] = v;
        end
        send_bit(ack_out, 1'b0, v);
        if (exp_rd_q.size() != 0) begin
            e = 1'b1;
            check_val(tag, 32'(b), 32'(exp_rd_q.pop_front()));
        end else begin
            e = 1'b0;
        end
        check_val({tag, "_scoreboarded"}, 32'(e), 32'd1);
    endtask

    int oe0, busy0;
`ifdef I2C_TARGET_GENCALL_EN
    int gc0;
`endif

    initial begin
        logic d;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
        check_val("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check_val("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_val("rst_wr_data", 32'(wr_data), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_q();

        // Basic write with auto-increment
        bus_start();
        wr_byte_chk(8'h72, 1'b0, "t1_addr_ack");
        check_val("t1_busy", 32'(busy), 32'd1);
        wr_byte_chk(8'h03, 1'b0, "t1_ptr_ack");
        wr_data_exp(4'h3, 8'hA5, "t1_d0_ack");
        wr_data_exp(4'h4, 8'h5A, "t1_d1_ack");
        bus_stop();
        wait_q();
        check_val("t1_busy_after_stop", 32'(busy), 32'd0);

        // Random read through repeated START, then current-address read
        bus_start();
        wr_byte_chk(8'h72, 1'b0, "t2_addr_ack");
        wr_byte_chk(8'h05, 1'b0, "t2_ptr_ack");
        wr_data_exp(4'h5, 8'hC3, "t2_d_ack");
        bus_stop();
        bus_start();
        wr_byte_chk(8'h72, 1'b0, "t2_waddr_ack");
        wr_byte_chk(8'h03, 1'b0, "t2_wptr_ack");
        bus_start();
        wr_byte_chk(8'h73, 1'b0, "t2_raddr_ack");
        exp_rd_q.push_back(8'hA5);
        exp_rd_q.push_back(8'h5A);
        read_byte(1'b0, "t2_rd0");
        read_byte(1'b1, "t2_rd1");
        wait_q();
        check_val("t2_idle_after_nack", 32'(busy), 32'd0);
        bus_stop();
        bus_start();
        wr_byte_chk(8'h73, 1'b0, "t2_cur_addr_ack");
        exp_rd_q.push_back(8'hC3);
        read_byte(1'b1, "t2_ptr_is_5");
        bus_stop();

        // Non-matching address
        oe0 = oe_cnt;
        busy0 = busy_cnt;
        bus_start();
        wr_byte_chk(8'h74, 1'b1, "t3_addr_nack");
        wr_byte_chk(8'h55, 1'b1, "t3_data_nack");
        bus_stop();
        check_val("t3_oe_never", 32'(oe_cnt - oe0), 32'd0);
        check_val("t3_busy_never", 32'(busy_cnt - busy0), 32'd0);

        // Pointer wrap on write and read-back
        bus_start();
        wr_byte_chk(8'h72, 1'b0, "t4_addr_ack");
        wr_byte_chk(8'h0F, 1'b0, "t4_ptr_ack");
        wr_data_exp(4'hF, 8'h11, "t4_d0_ack");
        wr_data_exp(4'h0, 8'h22, "t4_d1_ack");
        bus_start();
        wr_byte_chk(8'h72, 1'b0, "t4_waddr_ack");
        wr_byte_chk(8'hFF, 1'b0, "t4_wptr_ack");
        bus_start();
        wr_byte_chk(8'h73, 1'b0, "t4_raddr_ack");
        exp_rd_q.push_back(8'h11);
        exp_rd_q.push_back(8'h22);
        read_byte(1'b0, "t4_rd_f");
        read_byte(1'b1, "t4_rd_0");
        bus_stop();

        // One-clock SDA glitches while SCL high must not look like START/STOP
        bus_start();
        wr_byte_chk(8'h72, 1'b0, "t5_addr_ack");
        wr_byte_chk(8'h08, 1'b0, "t5_ptr_ack");
        exp_wr_q.push_back({4'h8, 8'h42});
        write_byte(8'h42, 1'b1, d);
        check_val("t5_glitch_ack", 32'(d), 32'd0);
        check_val("t5_glitch_busy", 32'(busy), 32'd1);
        bus_stop();

        // Reset in the middle of a data byte
        bus_start();
        wr_byte_chk(8'h72, 1'b0, "t6_addr_ack");
        wr_byte_chk(8'h02, 1'b0, "t6_ptr_ack");
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, d);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("t6_rst_oe", 32'(sda_oe), 32'd0);
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_recover();
        bus_start();
        wr_byte_chk(8'h72, 1'b0, "t6_waddr_ack");
        wr_byte_chk(8'h0F, 1'b0, "t6_wptr_ack");
        bus_start();
        wr_byte_chk(8'h73, 1'b0, "t6_raddr_ack");
        exp_rd_q.push_back(8'h00);
        exp_rd_q.push_back(8'h00);
        read_byte(1'b0, "t6_cleared_f");
        read_byte(1'b1, "t6_cleared_0");
        bus_stop();

        // Reset while the target is actively driving a read bit low
        bus_start();
        wr_byte_chk(8'h73, 1'b0, "t7_raddr_ack");
        send_bit(1'b1, 1'b0, d);
        check_val("t7_bit7_low", 32'(d), 32'd0);
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        check_val("t7_oe_driving", 32'(sda_oe), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("t7_rst_releases", 32'(sda_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_recover();

`ifdef I2C_TARGET_GENCALL_EN
        bus_start();
        wr_byte_chk(8'h00, 1'b0, "gc_addr_ack");
        gc0 = gc_cnt;
        wr_byte_chk(8'h06, 1'b0, "gc_byte_ack");
        check_val("gc_strobe_once", 32'(gc_cnt - gc0), 32'd1);
        wr_byte_chk(8'h77, 1'b1, "gc_third_nack");
        check_val("gc_idle", 32'(busy), 32'd0);
        bus_stop();
`else
        bus_start();
        wr_byte_chk(8'h00, 1'b1, "gc_addr_nack");
        bus_stop();
`endif

        wait_q();
        check_val("wr_unexpected", 32'(wr_unexp), 32'd0);
        check_val("wr_queue_left", 32'(exp_wr_q.size()), 32'd0);
        check_val("rd_queue_left", 32'(exp_rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
